// File: rtl/parking_gate_controller.sv
// parking_gate_controller: single-lane parking gate arbiter with per-grant timeout,
// post-grant closed gap and saturating lot occupancy count.
`default_nettype none

module parking_gate_controller #(
   parameter  int CAPACITY = 8,
   parameter  int TIMEOUT  = 16,
   parameter  int GAP      = 2,
   localparam int CW       = $clog2(CAPACITY + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          entry_req,
   input  logic          exit_req,
   input  logic          enter,
   input  logic          exit,
   output logic          gate_open,
   output logic          entry_grant,
   output logic          exit_grant,
   output logic          abort,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int TW = $clog2(TIMEOUT + GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_EXIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   typedef enum logic {
      DIR_ENTRY = 1'b0,
      DIR_EXIT  = 1'b1
   } dir_t;

   state_t        state, state_nx;
   dir_t          last_served, last_served_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          abort_nx;
   logic          entry_ok, exit_ok, matched, expired;

   assign entry_ok = entry_req & ~full;
   assign exit_ok  = exit_req & ~empty;
   assign matched  = (state == S_ENTRY) ? enter : exit;
   assign expired  = (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         last_served <= DIR_EXIT;
         timer       <= '0;
         abort       <= 1'b0;
      end else begin
         state       <= state_nx;
         last_served <= last_served_nx;
         timer       <= timer_nx;
         abort       <= abort_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      last_served_nx = last_served;
      timer_nx       = timer;
      abort_nx       = 1'b0;
      case (state)
         S_IDLE: begin
            // With both directions eligible, serve the one not served last.
            if (entry_ok && (!exit_ok || last_served == DIR_EXIT)) begin
               state_nx       = S_ENTRY;
               last_served_nx = DIR_ENTRY;
               timer_nx       = '0;
            end else if (exit_ok) begin
               state_nx       = S_EXIT;
               last_served_nx = DIR_EXIT;
               timer_nx       = '0;
            end
         end
         S_ENTRY, S_EXIT: begin
            if (matched || expired) begin
               state_nx = S_GAP;
               timer_nx = '0;
               abort_nx = ~matched;
            end else begin
               timer_nx = timer + TW'(1);
            end
         end
         S_GAP: begin
            if (timer == TW'(GAP - 1)) begin
               state_nx = S_IDLE;
               timer_nx = '0;
            end else begin
               timer_nx = timer + TW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // The detector reports physical movement, so the count follows it in every state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (enter && !exit && count != CW'(CAPACITY)) begin
         count <= count + CW'(1);
      end else if (exit && !enter && count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign gate_open   = (state == S_ENTRY) || (state == S_EXIT);
   assign entry_grant = (state == S_ENTRY);
   assign exit_grant  = (state == S_EXIT);
   assign full        = (count == CW'(CAPACITY));
   assign empty       = (count == '0);

endmodule

`default_nettype wire
